cmd_dispatcher: RTL and testbench
=================================

Name: cmd_dispatcher

Overview:
- Consumes the 128-bit AXI-Stream command words the PS writes into the command FIFO, decodes each opcode and sequences it.
- Forwards DDR command slots to the DDR command issue path, inserts programmed idle gaps, and signals program end.
- Reports status back to the PS over GPIO: busy, error, issued count and end count.
- Sits between the command FIFO master side and the DDR4 command issue logic.

Parameters:
- CMD_WIDTH, 128, width of the S_AXIS command word.
- DDR_CMD_WIDTH, 32, width of the DDR command slot forwarded downstream; taken from cmd[DDR_CMD_WIDTH-1:0].
- WAIT_WIDTH, 32, width of the WAIT cycle count.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- axi_aclk  in  1  single clock.
- axi_resetn  in  1  asynchronous active-low reset.
- run  in  1  level enable; new commands are accepted only while high.
- S_AXIS_CMD_tdata  in  CMD_WIDTH  command word.
- S_AXIS_CMD_tvalid  in  1  command valid.
- S_AXIS_CMD_tready  out  1  dispatcher can accept a command.
- ddr_cmd_data  out  DDR_CMD_WIDTH  DDR command slot.
- ddr_cmd_valid  out  1  slot valid.
- ddr_cmd_ready  in  1  downstream accepts the slot.
- end_pulse  out  1  one-cycle pulse on an END command.
- busy  out  1  state != IDLE.
- err  out  1  sticky illegal-opcode flag.
- err_clr  in  1  clears err.
- issued_count  out  CNT_WIDTH  ISSUE handshakes completed; wraps modulo 2^CNT_WIDTH.
- end_count  out  CNT_WIDTH  END commands executed; wraps.
- last_end_cycles  out  32  optional trace output (see Optional Feature).

Behaviour:
- Reset values:
  - all outputs 0, state IDLE, counters 0, err 0.
  - Reset mid-operation aborts any ISSUE or WAIT immediately; a pending slot is dropped.
- Opcode in cmd[127:124]:
  - 0 NOP
  - 1 ISSUE
  - 2 WAIT
  - 3 END
  - 4-15 illegal
- S_AXIS_CMD_tready = (state==IDLE) && run, driven combinationally from registers. An accept is a tvalid&&tready cycle T.
- IDLE, on accept:
  - NOP: stay in IDLE; tready stays high at T+1.
  - ISSUE: latch ddr_cmd_data; ddr_cmd_valid=1 from T+1; go to ISSUE.
  - WAIT with N=cmd[WAIT_WIDTH-1:0]: N=0 behaves as NOP. Otherwise load the counter with N and go to WAIT.
  - END: end_pulse high exactly at T+1; end_count increments at T+1; stay in IDLE.
  - Illegal: command is dropped; err=1 at T+1; stay in IDLE.
- ISSUE state:
  - ddr_cmd_valid and ddr_cmd_data stay stable until ddr_cmd_ready.
  - On the handshake cycle H: valid falls at H+1, issued_count increments at H+1, state returns to IDLE at H+1.
  - A new command can therefore be accepted at H+1 at the earliest (one slot per 2 cycles maximum; back-to-back throughput is not required).
- WAIT state:
  - The counter decrements each cycle; at counter==1 the state goes to IDLE.
  - WAIT N accepted at T gives tready high again at T+N+1.
- Dropping run:
  - In IDLE, stops acceptance immediately; tdata/tvalid are left in the FIFO.
  - In ISSUE or WAIT, the current command completes, then the block idles.
- err_clr and a new illegal opcode in the same cycle: set wins. err_clr otherwise clears err next cycle.
- Counter wrap: 0xFFFF+1 → 0, with no flag.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro CMD_DISPATCH_TRACE_EN.
- Defined:
  - A 32-bit cycle counter clears on the first accept after reset or after an END, and increments every cycle afterwards (saturates at 0xFFFFFFFF).
  - On END, the counter value is copied to last_end_cycles at T+1.
- Undefined: last_end_cycles is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package/header `cmd_dispatch_defs.vh`:
  - opcode constants OP_NOP/OP_ISSUE/OP_WAIT/OP_END
  - opcode field bounds (127:124)
  - state encodings ST_IDLE/ST_ISSUE/ST_WAIT
- One natural sub-module: `cmd_wait_timer` (loadable down-counter with a done strobe), used for the WAIT state.
- Everything else is inline.

Test Plan:
- run=1, ISSUE with cmd[31:0]=0x0012_3456, ddr_cmd_ready held low 5 cycles then high → ddr_cmd_valid high from T+1 with data stable at 0x00123456; issued_count=1 at H+1; tready high at H+1.
- WAIT N=10 accepted at T → busy high T+1..T+10, tready high at T+11; WAIT N=0 → tready high at T+1, busy never asserts.
- Opcode 0x7, then err_clr raised in the same cycle as a second 0x7 → err=1 after the first; err stays 1; err_clr alone later → err=0 next cycle; no ddr_cmd_valid at any point.
- Sequence ISSUE, ISSUE, END with ddr_cmd_ready tied high → two ddr handshakes, one end_pulse, end_count=1, issued_count=2.
- run dropped during WAIT 20 → WAIT completes, then tready stays 0 while the FIFO holds a command; run=1 → accepted next cycle. Separately, axi_resetn asserted mid-ISSUE → valid=0 immediately, counters=0.
- With CMD_DISPATCH_TRACE_EN: NOP at T0, WAIT 50, END → last_end_cycles=52 (51 cycles for the WAIT, plus one for the END accept). Without the macro → last_end_cycles=0.

Source files
------------

// File: rtl/cmd_dispatcher_pkg.sv
// cmd_dispatcher_pkg: opcode constants, opcode field bounds and FSM state encoding.
package cmd_dispatcher_pkg;
  localparam int OP_HI = 127;
  localparam int OP_LO = 124;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ISSUE = 4'd1;
  localparam logic [3:0] OP_WAIT  = 4'd2;
  localparam logic [3:0] OP_END   = 4'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
endpackage

// File: rtl/cmd_dispatcher_if.sv
// cmd_dispatcher_if: valid/ready stream used for the command input and the DDR slot output.
interface cmd_dispatcher_if #(parameter int W = 128) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/cmd_wait_timer.sv
// cmd_wait_timer: loadable down-counter; done is high while the count sits at 1.
module cmd_wait_timer #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0) ? cnt - W'(1) : cnt;
  end
  assign done = cnt == W'(1);
endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes PS command words into DDR slots, idle gaps and program-end events.
// Optional CMD_DISPATCH_TRACE_EN adds a cycle counter captured into last_end_cycles on END.
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int CMD_WIDTH     = 128,
  parameter int DDR_CMD_WIDTH = 32,
  parameter int WAIT_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic                 run,
  cmd_dispatcher_if.slave      s_axis_cmd,
  cmd_dispatcher_if.master     ddr_cmd,
  output logic                 end_pulse,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] issued_count,
  output logic [CNT_WIDTH-1:0] end_count,
  output logic [31:0]          last_end_cycles
);
  state_e                  state;
  logic [DDR_CMD_WIDTH-1:0] slot;
  logic                    slot_valid;
  logic [3:0]              op;
  logic [WAIT_WIDTH-1:0]   wait_n;
  logic                    accept;
  logic                    wait_load;
  logic                    wait_done;
  logic                    end_acc;
  logic                    unused_bits;

  assign op          = s_axis_cmd.tdata[OP_HI:OP_LO];
  assign wait_n      = s_axis_cmd.tdata[WAIT_WIDTH-1:0];
  assign s_axis_cmd.tready = (state == ST_IDLE) && run;
  assign accept      = s_axis_cmd.tvalid && s_axis_cmd.tready;
  assign wait_load   = accept && op == OP_WAIT && wait_n != '0;
  assign end_acc     = accept && op == OP_END;
  assign ddr_cmd.tdata  = slot;
  assign ddr_cmd.tvalid = slot_valid;
  assign unused_bits = ^s_axis_cmd.tdata;

  cmd_wait_timer #(.W(WAIT_WIDTH)) u_wait_timer (
    .clk      (axi_aclk),
    .rst_n    (axi_resetn),
    .load     (wait_load),
    .load_val (wait_n),
    .done     (wait_done)
  );

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      slot         <= '0;
      slot_valid   <= 1'b0;
      end_pulse    <= 1'b0;
      err          <= 1'b0;
      issued_count <= '0;
      end_count    <= '0;
    end else begin
      end_pulse <= end_acc;
      end_count <= end_count + CNT_WIDTH'(end_acc);
      // a fresh illegal opcode takes priority over a simultaneous clear
      err       <= (accept && op > OP_END) || (err && !err_clr);
      case (state)
        ST_IDLE: begin
          if (accept && op == OP_ISSUE) begin
            slot       <= s_axis_cmd.tdata[DDR_CMD_WIDTH-1:0];
            slot_valid <= 1'b1;
            state      <= ST_ISSUE;
            busy       <= 1'b1;
          end else if (wait_load) begin
            state <= ST_WAIT;
            busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (ddr_cmd.tready) begin
            slot_valid   <= 1'b0;
            issued_count <= issued_count + CNT_WIDTH'(1);
            state        <= ST_IDLE;
            busy         <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_DISPATCH_TRACE_EN
  logic [31:0] cyc;
  logic [31:0] cyc_next;
  logic        cyc_arm;
  assign cyc_next = (cyc == '1) ? cyc : cyc + 32'd1;
  // cyc_arm marks that the next accept restarts the measurement window
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cyc             <= '0;
      cyc_arm         <= 1'b1;
      last_end_cycles <= '0;
    end else begin
      cyc     <= (accept && cyc_arm) ? '0 : cyc_next;
      cyc_arm <= end_acc ? 1'b1 : accept ? 1'b0 : cyc_arm;
      if (end_acc) last_end_cycles <= cyc_arm ? '0 : cyc_next;
    end
  end
`else
  assign last_end_cycles = '0;
`endif
endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed self-checking bench for cmd_dispatcher.
module tb_cmd_dispatcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        err_clr = 1'b0;
  logic        end_pulse, busy, err;
  logic [15:0] issued_count, end_count;
  logic [31:0] last_end_cycles;
  int passed = 0;
  int total = 0;
  int hs = 0;
  int ep = 0;
  int vseen = 0;

  cmd_dispatcher_if #(.W(128)) s_axis ();
  cmd_dispatcher_if #(.W(32))  ddr ();

  cmd_dispatcher dut (
    .axi_aclk        (clk),
    .axi_resetn      (rst_n),
    .run             (run),
    .s_axis_cmd      (s_axis),
    .ddr_cmd         (ddr),
    .end_pulse       (end_pulse),
    .busy            (busy),
    .err             (err),
    .err_clr         (err_clr),
    .issued_count    (issued_count),
    .end_count       (end_count),
    .last_end_cycles (last_end_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ddr.tvalid && ddr.tready) hs++;
    if (end_pulse) ep++;
    if (ddr.tvalid) vseen++;
  end

  function automatic logic [127:0] mk(input logic [3:0] op, input logic [31:0] lo);
    return {op, 92'h5A5, lo};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    ddr.tready = 1'b0;
    err_clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [127:0] c);
    bit ok;
    ok = 1'b0;
    s_axis.tdata = c;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = s_axis.tready;
      @(posedge clk); #1;
    end
    s_axis.tvalid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL send: command %h not accepted within 200 cycles", c);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ddr.tvalid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ddr.tvalid); else passed++;
    total++; if (busy !== 1'b0 || end_pulse !== 1'b0 || err !== 1'b0) $display("FAIL reset_flags: busy=%b end_pulse=%b err=%b want 000", busy, end_pulse, err); else passed++;
    total++; if (issued_count !== 16'd0 || end_count !== 16'd0) $display("FAIL reset_counts: issued=%0d end=%0d want 0 0", issued_count, end_count); else passed++;
    total++; if (last_end_cycles !== 32'd0) $display("FAIL reset_trace: got %0d want 0", last_end_cycles); else passed++;
    total++; if (s_axis.tready !== 1'b0) $display("FAIL reset_tready_run0: got %b want 0", s_axis.tready); else passed++;
    run = 1'b1;
    #1;
    total++; if (s_axis.tready !== 1'b1) $display("FAIL tready_run1: got %b want 1", s_axis.tready); else passed++;
  endtask

  task automatic test_issue();
    int bad;
    bad = 0;
    send(mk(4'h1, 32'h0012_3456));
    total++; if (ddr.tvalid !== 1'b1 || ddr.tdata !== 32'h0012_3456) $display("FAIL issue_first: valid=%b data=%h want 1 00123456", ddr.tvalid, ddr.tdata); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (ddr.tvalid !== 1'b1 || ddr.tdata !== 32'h0012_3456 || s_axis.tready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad !== 0) $display("FAIL issue_stable: %0d unstable cycles want 0", bad); else passed++;
    ddr.tready = 1'b1;
    @(posedge clk); #1;
    ddr.tready = 1'b0;
    total++; if (ddr.tvalid !== 1'b0 || issued_count !== 16'd1) $display("FAIL issue_handshake: valid=%b issued=%0d want 0 1", ddr.tvalid, issued_count); else passed++;
    total++; if (s_axis.tready !== 1'b1 || busy !== 1'b0) $display("FAIL issue_return: tready=%b busy=%b want 1 0", s_axis.tready, busy); else passed++;
  endtask

  task automatic test_wait();
    int bad;
    bad = 0;
    send(mk(4'h2, 32'd10));
    for (int k = 1; k <= 10; k++) begin
      if (busy !== 1'b1 || s_axis.tready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    total++; if (bad !== 0) $display("FAIL wait10_busy: %0d bad cycles want 0", bad); else passed++;
    total++; if (busy !== 1'b0 || s_axis.tready !== 1'b1) $display("FAIL wait10_end: busy=%b tready=%b want 0 1", busy, s_axis.tready); else passed++;
    send(mk(4'h2, 32'd0));
    total++; if (busy !== 1'b0 || s_axis.tready !== 1'b1) $display("FAIL wait0: busy=%b tready=%b want 0 1", busy, s_axis.tready); else passed++;
    send(mk(4'h2, 32'd1));
    total++; if (busy !== 1'b1) $display("FAIL wait1_busy: got %b want 1", busy); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || s_axis.tready !== 1'b1) $display("FAIL wait1_end: busy=%b tready=%b want 0 1", busy, s_axis.tready); else passed++;
  endtask

  task automatic test_err();
    int v0;
    v0 = vseen;
    send(mk(4'h7, 32'h1));
    total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passed++;
    err_clr = 1'b1;
    send(mk(4'h7, 32'h2));
    err_clr = 1'b0;
    total++; if (err !== 1'b1) $display("FAIL err_set_wins: got %b want 1", err); else passed++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    total++; if (err !== 1'b0) $display("FAIL err_clr: got %b want 0", err); else passed++;
    total++; if (vseen !== v0 || busy !== 1'b0) $display("FAIL err_no_valid: valid cycles=%0d busy=%b want 0 0", vseen - v0, busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int h0, e0;
    do_reset();
    ddr.tready = 1'b1;
    h0 = hs;
    e0 = ep;
    send(mk(4'h1, 32'hA0A0_0001));
    send(mk(4'h1, 32'hA0A0_0002));
    send(mk(4'h3, 32'h0));
    total++; if (end_pulse !== 1'b1) $display("FAIL end_pulse_t1: got %b want 1", end_pulse); else passed++;
    @(posedge clk); #1;
    total++; if (end_pulse !== 1'b0) $display("FAIL end_pulse_t2: got %b want 0", end_pulse); else passed++;
    total++; if (hs - h0 !== 2 || ep - e0 !== 1) $display("FAIL b2b_events: handshakes=%0d pulses=%0d want 2 1", hs - h0, ep - e0); else passed++;
    total++; if (issued_count !== 16'd2 || end_count !== 16'd1) $display("FAIL b2b_counts: issued=%0d end=%0d want 2 1", issued_count, end_count); else passed++;
    ddr.tready = 1'b0;
  endtask

  task automatic test_run_drop();
    int bad_rdy, bad_busy;
    bad_rdy = 0;
    bad_busy = 0;
    do_reset();
    send(mk(4'h2, 32'd20));
    run = 1'b0;
    s_axis.tdata = mk(4'h1, 32'hCAFE_0001);
    s_axis.tvalid = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      if (s_axis.tready !== 1'b0) bad_rdy++;
      if ((i <= 20 && busy !== 1'b1) || (i > 20 && busy !== 1'b0)) bad_busy++;
      @(posedge clk); #1;
    end
    total++; if (bad_rdy !== 0 || ddr.tvalid !== 1'b0) $display("FAIL run_drop_hold: tready cycles=%0d valid=%b want 0 0", bad_rdy, ddr.tvalid); else passed++;
    total++; if (bad_busy !== 0) $display("FAIL run_drop_wait: %0d bad busy cycles want 0", bad_busy); else passed++;
    run = 1'b1;
    #1;
    total++; if (s_axis.tready !== 1'b1) $display("FAIL run_resume_tready: got %b want 1", s_axis.tready); else passed++;
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
    total++; if (ddr.tvalid !== 1'b1 || ddr.tdata !== 32'hCAFE_0001) $display("FAIL run_resume_accept: valid=%b data=%h want 1 cafe0001", ddr.tvalid, ddr.tdata); else passed++;
    ddr.tready = 1'b1;
    @(posedge clk); #1;
    ddr.tready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    send(mk(4'h1, 32'hBEEF_0001));
    total++; if (ddr.tvalid !== 1'b1 || issued_count !== 16'd1) $display("FAIL mid_pre: valid=%b issued=%0d want 1 1", ddr.tvalid, issued_count); else passed++;
    #3 rst_n = 1'b0;
    #1;
    total++; if (ddr.tvalid !== 1'b0 || busy !== 1'b0 || issued_count !== 16'd0 || end_count !== 16'd0) $display("FAIL mid_reset: valid=%b busy=%b issued=%0d end=%0d want 0 0 0 0", ddr.tvalid, busy, issued_count, end_count); else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ddr.tvalid !== 1'b0 || s_axis.tready !== 1'b1) $display("FAIL mid_after: valid=%b tready=%b want 0 1", ddr.tvalid, s_axis.tready); else passed++;
  endtask

  task automatic test_trace();
    logic [31:0] exp;
`ifdef CMD_DISPATCH_TRACE_EN
    exp = 32'd52;
`else
    exp = 32'd0;
`endif
    do_reset();
    send(mk(4'h0, 32'h0));
    send(mk(4'h2, 32'd50));
    send(mk(4'h3, 32'h0));
    total++; if (last_end_cycles !== exp) $display("FAIL trace_last_end: got %0d want %0d", last_end_cycles, exp); else passed++;
    total++; if (end_count !== 16'd1) $display("FAIL trace_end_count: got %0d want 1", end_count); else passed++;
  endtask

  initial begin
    s_axis.tdata = '0;
    s_axis.tvalid = 1'b0;
    ddr.tready = 1'b0;
    test_reset();
    test_issue();
    test_wait();
    test_err();
    test_back_to_back();
    test_run_drop();
    test_reset_mid_issue();
    test_trace();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
